pipe_muldiv: RTL and testbench
==============================

# pipe_muldiv

Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core. It sits beside the EXE-stage ALU and accepts MULT/MULTU/DIV/DIVU from EXE. It runs each operation over a fixed 34-cycle schedule, and raises a stall to the pipeline whenever an instruction needs the unit or HI/LO while an operation is in flight. MTHI/MTLO writes and MFHI/MFLO reads are arbitrated against the running operation here.

## Interface

Parameters:
- none; the datapath is fixed at 32 bits and the latency is fixed at 34 cycles.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EXE holds a mul/div instruction; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- hilo_we  in  1  MTHI/MTLO in EXE
- hilo_sel  in  1  target or source select: 0 LO, 1 HI
- hilo_wd  in  32  MTHI/MTLO data
- hilo_re  in  1  MFHI/MFLO in EXE
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight (state != IDLE)
- stall  out  1  freeze IF/ID/EXE this cycle
- done  out  1  one-cycle pulse when HI/LO take a new result

## Operation

- FSM states: IDLE, RUN, FIX.
- IDLE with start=1:
  - latch op, rs_val and rt_val into internal registers;
  - clear the 5-bit counter;
  - go to RUN.
- Operand conditioning at the start edge:
  - for signed ops, store magnitudes plus two sign bits;
  - for unsigned ops, store the raw values.
- RUN lasts exactly 32 cycles; the counter increments each cycle and leaves for FIX when it reaches 31.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 64-bit product.
- RUN, divide: restoring divide, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
- FIX lasts one cycle and applies sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - At the end of FIX, write HI←product[63:32] / remainder and LO←product[31:0] / quotient, then go to IDLE.
- done is registered and is 1 in the first IDLE cycle after FIX.
- Divide by zero (rt_val==0, DIV or DIVU): HI←rs_val and LO←32'hFFFFFFFF. The full 34-cycle schedule still runs.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO←32'h80000000, HI←0. No exception is raised.
- stall = busy & (start | hilo_re | hilo_we), combinational.
  - start while busy is ignored; the upstream stall holds the instruction until IDLE.
- hilo_we in IDLE writes the register selected by hilo_sel at the clock edge.
- hilo_we while busy is not performed and stall is asserted.
- If start and hilo_we are both 1 in IDLE, the MT write is done and start is ignored (cannot occur in legal code).
- hi and lo are register outputs and are always readable. The pipeline must gate MFHI/MFLO with stall.

## Timing

- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. stall=0 follows from busy=0.
- Reset mid-operation: the next edge returns the block to IDLE, abandons the operation and clears HI/LO. done is not pulsed.
- Schedule, with start sampled at edge 0:
  - RUN occupies cycles 1–32;
  - FIX is cycle 33;
  - HI/LO update at the edge ending cycle 33;
  - done=1 and the new hi/lo are visible in cycle 34.
- busy=1 in cycles 1–33. A new start is accepted in cycle 34 at the earliest, so back-to-back throughput is one operation per 34 cycles.
- An MFHI held from cycle 5: stall=1 in cycles 5–33 and 0 in cycle 34, when the read sees the new value.
- hilo_we in IDLE: the new value is visible on hi/lo the next cycle.

## Test plan

- MULTU rs=32'hFFFFFFFF, rt=32'hFFFFFFFF -> in cycle 34, hi=32'hFFFFFFFE, lo=32'h00000001, done=1 for exactly one cycle; busy=1 in cycles 1–33.
- MULT rs=-3, rt=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Then DIV rs=-7, rt=2 issued in cycle 34 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF at cycle 68.
- DIVU rs=32'h12345678, rt=0 -> hi=32'h12345678, lo=32'hFFFFFFFF, still at cycle 34. DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- Hazards during a MULT:
  - hilo_re held from cycle 3 -> stall=1 in cycles 3–33, 0 in cycle 34;
  - hilo_we=1, hilo_sel=1, hilo_wd=32'hAAAA5555 held from cycle 3 -> stall asserted and HI not written until the IDLE cycle;
  - start held while busy -> ignored; the operation begins only at the cycle-34 edge.
- MTLO 32'hDEADBEEF in IDLE -> lo=32'hDEADBEEF next cycle, hi unchanged, stall=0.
- Start a DIVU, assert rst in cycle 10 -> next cycle busy=0, hi=lo=0; no done pulse follows; a fresh MULTU 6×7 then yields lo=42, hi=0 at its cycle 34.

Source files
------------

// File: rtl/pipe_muldiv.sv
// Iterative 32-bit multiply/divide unit owning HI/LO for the pipelined MIPS core.
// Fixed 34-cycle schedule: one start cycle, 32 RUN cycles, one FIX cycle for sign correction.
module pipe_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wd,
    input  logic        hilo_re,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_signed;
    logic        r_neg_a;
    logic        r_neg_b;
    logic        r_div0;
    logic [31:0] r_a;       // multiplicand, or dividend shifting into quotient
    logic [31:0] r_b;       // multiplier (shifts right), or divisor
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_accept;
    logic        w_op_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_qbit;
    logic [31:0] w_diff;
    logic        w_neg_res;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // A simultaneous MT write wins over start in IDLE.
    assign w_accept    = (r_state == S_IDLE) && start && !hilo_we;
    assign w_op_signed = !op[0];
    assign w_rs_neg    = w_op_signed && rs_val[31];
    assign w_rt_neg    = w_op_signed && rt_val[31];
    assign w_rs_mag    = w_rs_neg ? (32'd0 - rs_val) : rs_val;
    assign w_rt_mag    = w_rt_neg ? (32'd0 - rt_val) : rt_val;

    assign w_sum   = {1'b0, r_prod[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};
    assign w_shift = {r_rem, r_a[31]};
    assign w_qbit  = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[31:0] - r_b;

    assign w_neg_res  = r_signed && (r_neg_a ^ r_neg_b);
    assign w_prod_fix = w_neg_res ? (64'd0 - r_prod) : r_prod;
    assign w_quo_fix  = w_neg_res ? (32'd0 - r_a) : r_a;
    assign w_rem_fix  = (r_signed && r_neg_a) ? (32'd0 - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == 5'd31) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != S_IDLE);
        stall = busy && (start || hilo_re || hilo_we);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_div0   <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_prod   <= 64'd0;
            r_rem    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (hilo_we) begin
                        if (hilo_sel) r_hi <= hilo_wd;
                        else          r_lo <= hilo_wd;
                    end else if (start) begin
                        r_cnt    <= 5'd0;
                        r_is_div <= op[1];
                        r_signed <= w_op_signed;
                        r_neg_a  <= w_rs_neg;
                        r_neg_b  <= w_rt_neg;
                        r_div0   <= op[1] && (rt_val == 32'd0);
                        r_a      <= w_rs_mag;
                        r_b      <= w_rt_mag;
                        r_prod   <= 64'd0;
                        r_rem    <= 32'd0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_is_div) begin
                        r_rem <= w_qbit ? w_diff : w_shift[31:0];
                        r_a   <= {r_a[30:0], w_qbit};
                    end else begin
                        r_prod <= {w_sum, r_prod[31:1]};
                        r_b    <= {1'b0, r_b[31:1]};
                    end
                end
                S_FIX: begin
                    // Divide by zero: corrected remainder equals the raw dividend.
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= r_div0 ? 32'hFFFF_FFFF : w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;

endmodule

// File: tb/tb_pipe_muldiv.sv
// Directed bench for pipe_muldiv: schedule, results, sign cases, hazards and reset abort.
// Inputs change #1 after a rising edge; outputs are sampled in the same window.
module tb_pipe_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hilo_we;
    logic        hilo_sel;
    logic [31:0] hilo_wd;
    logic        hilo_re;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    pipe_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wd(hilo_wd), .hilo_re(hilo_re),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Presents an operation for the start edge; afterwards the bench sits in cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        step();
        start = 1'b0;
        cyc   = 1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = 32'd0; rt_val = 32'd0;
        hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wd = 32'd0; hilo_re = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);

        // MTLO in IDLE
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wd = 32'hDEADBEEF;
        #1;
        chk("mtlo_stall", stall, 0);
        step();
        hilo_we = 1'b0;
        chk("mtlo_lo", lo, 32'hDEADBEEF);
        chk("mtlo_hi", hi, 0);

        // MULTU max x max, with busy profile
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        while (cyc < 34) begin
            chk("multu_busy", busy, 1);
            if (cyc != 33) chk("multu_nodone", done, 0);
            step();
        end
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        chk("multu_done", done, 1);
        chk("multu_idle", busy, 0);
        step();
        chk("multu_done_pulse", done, 0);

        // MULT -3 x 5 with MFHI held from cycle 3
        issue(2'b00, 32'hFFFFFFFD, 32'd5);
        run_to(3);
        hilo_re = 1'b1;
        #1;
        while (cyc < 34) begin
            chk("mfhi_stall", stall, 1);
            step();
        end
        chk("mfhi_stall_rel", stall, 0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        chk("mult_done", done, 1);
        hilo_re = 1'b0;

        // DIV -7 / 2 issued in cycle 34, result at cycle 68
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        run_to(34);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_done", done, 1);

        // DIVU by zero
        issue(2'b11, 32'h12345678, 32'd0);
        run_to(33);
        chk("divz_busy33", busy, 1);
        step();
        chk("divz_hi", hi, 32'h12345678);
        chk("divz_lo", lo, 32'hFFFFFFFF);
        chk("divz_done", done, 1);

        // DIV overflow case
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_to(34);
        chk("divovf_lo", lo, 32'h80000000);
        chk("divovf_hi", hi, 0);

        // MULT 2 x 3 with MTHI held from cycle 3
        issue(2'b00, 32'd2, 32'd3);
        run_to(3);
        hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wd = 32'hAAAA5555;
        #1;
        while (cyc < 34) begin
            chk("mthi_stall", stall, 1);
            chk("mthi_hi_held", hi, 0);
            step();
        end
        chk("mthi_stall_rel", stall, 0);
        chk("mult2_hi", hi, 0);
        chk("mult2_lo", lo, 32'd6);
        step();
        hilo_we = 1'b0;
        chk("mthi_hi", hi, 32'hAAAA5555);
        chk("mthi_lo", lo, 32'd6);

        // start held while busy: MULTU 6x7, then 10x10 waits for IDLE
        start = 1'b1; op = 2'b01; rs_val = 32'd6; rt_val = 32'd7;
        step();
        cyc = 1;
        rs_val = 32'd10; rt_val = 32'd10;
        #1;
        while (cyc < 34) begin
            chk("hold_stall", stall, 1);
            step();
        end
        chk("hold_busy34", busy, 0);
        chk("hold_stall34", stall, 0);
        chk("hold_lo1", lo, 32'd42);
        chk("hold_done1", done, 1);
        step();
        start = 1'b0;
        chk("hold_busy_new", busy, 1);
        chk("hold_done_new", done, 0);
        cyc = 1;
        run_to(34);
        chk("hold_lo2", lo, 32'd100);
        chk("hold_hi2", hi, 0);

        // Reset mid-DIVU
        issue(2'b11, 32'd100, 32'd7);
        run_to(10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        for (int i = 0; i < 36; i++) begin
            chk("abort_nodone", done, 0);
            step();
        end
        issue(2'b01, 32'd6, 32'd7);
        run_to(34);
        chk("post_lo", lo, 32'd42);
        chk("post_hi", hi, 0);
        chk("post_done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
